ddr3_req_arbiter: RTL and testbench
===================================

Name: ddr3_req_arbiter

Overview:
- Two-requester command scheduler in front of the DDR3 memory-controller user interface, in the sclk_out domain.
- Sequences controller init (init_start/init_done) and round-robin arbitrates read/write commands.
- Steers write-data pulls (datain_rdy) to the granted writer.
- Routes returned read beats to the requester that issued the read, via an in-order tag FIFO.

Parameters:
- BEATS_PER_BURST, 2: 128-bit user beats per cmd_burst_cnt unit.
- RD_TAG_DEPTH, 4: outstanding read commands tracked (power of 2).
- CMD_READ, 4'b0001: controller read opcode.
- CMD_WRITE, 4'b0010: controller write opcode.
- OFLY_BL, 1'b0: value driven on ofly_burst_len.

Ports:
- sclk  in  1  user clock (controller sclk_out).
- rst_n  in  1  async active-low reset.
- rN_req  in  1  requester N (N=0,1) command request, held until rN_grant.
- rN_rnw  in  1  1=read, 0=write.
- rN_addr  in  28  command address.
- rN_burst_cnt  in  5  burst count; 0 encodes 32.
- rN_grant  out  1  one-cycle pulse: command accepted by controller.
- rN_wdata  in  128  write beat.
- rN_wmask  in  16  write byte mask.
- rN_wdata_rdy  out  1  beat consumed this cycle.
- rN_rdata  out  128  read beat (shared, = read_data).
- rN_rdata_valid  out  1  read beat valid for N.
- init_start  out  1  to controller.
- init_done  in  1  from controller.
- cmd  out  4  to controller.
- addr  out  28  to controller.
- cmd_burst_cnt  out  5  to controller.
- cmd_valid  out  1  to controller.
- cmd_rdy  in  1  from controller.
- datain_rdy  in  1  from controller.
- write_data  out  128  to controller.
- data_mask  out  16  to controller.
- read_data  in  128  from controller.
- read_data_valid  in  1  from controller.
- ofly_burst_len  out  1  constant OFLY_BL.
- busy  out  1  FSM not in IDLE, or tag FIFO non-empty.
- rd_err  out  1  sticky: read_data_valid seen with tag FIFO empty.

Behaviour:
- Reset (async, any time incl. mid-burst):
  - FSM=INIT; tag FIFO emptied; counters 0; rr pointer=0 (requester 0 favoured first); rd_err=0.
  - All outputs 0 except ofly_burst_len=OFLY_BL.
  - In-flight controller transactions are abandoned.
- INIT: init_start=1 from the first cycle after reset release until init_done=1 is sampled. Then init_start=0 and FSM goes to IDLE. No grants in INIT.
- Eligibility: rN_req=1, and, if rN_rnw=1, tag FIFO not full.
- IDLE: if any requester is eligible, pick one round-robin.
  - Priority goes to the requester not granted last; with a single eligible requester, it wins.
  - Latch id, rnw, addr, burst_cnt. Update the rr pointer at grant.
  - Next state CMD.
- CMD:
  - Drive cmd_valid=1, cmd=CMD_READ/CMD_WRITE, plus addr and cmd_burst_cnt from the latch. Hold stable until cmd_rdy=1.
  - On cmd_valid&cmd_rdy: pulse rN_grant for one cycle; cmd_valid=0 next cycle.
  - Write: load wbeats = (burst_cnt==0?32:burst_cnt)*BEATS_PER_BURST; go to WDATA.
  - Read: push {id, same beat count} to the tag FIFO; go to IDLE.
- WDATA:
  - write_data/data_mask = combinational mux of the owner's rN_wdata/rN_wmask.
  - rN_wdata_rdy = datain_rdy & (owner==N).
  - Each datain_rdy decrements wbeats; on the last beat (wbeats==1) go to IDLE.
  - No new command is issued until all write beats are transferred.
  - Outside WDATA, write_data = r0_wdata and data_mask = r0_wmask. datain_rdy outside WDATA is ignored.
- Read return:
  - A head beat counter is loaded from the FIFO head.
  - Each read_data_valid asserts rN_rdata_valid for the head id, same cycle (combinational), and decrements.
  - At the last beat, pop. A push and a pop in the same cycle are both honoured; occupancy is unchanged.
  - Read return runs concurrently with any FSM state.
- Full/empty:
  - FIFO full blocks read grants only; writes still proceed.
  - read_data_valid with FIFO empty sets rd_err and routes the beat to nobody.
- Width: the beat count is 7 bits (max 64).

Test Plan:
- Reset release, init_done asserted 20 cycles later -> init_start high for exactly those cycles; no cmd_valid before init_done.
- r0 write at addr 0x0000100, burst_cnt 1; cmd_rdy after 3 cycles -> cmd=0010 held 3 cycles, r0_grant one pulse, 2 datain_rdy pulses drive r0_wdata and r0_wdata_rdy, then IDLE.
- r0 and r1 both request continuously -> grants alternate r0,r1,r0,r1.
- r1 read burst_cnt 0 -> 64 read_data_valid beats all appear on r1_rdata_valid; r0_rdata_valid stays 0.
- r0 issues 5 reads of burst_cnt 1 with no read data returned -> 4 grants, 5th blocked; r1 write still granted. After 2 beats return, 5th granted.
- read_data_valid pulse with no outstanding read -> rd_err=1 and stays set until reset. Reset asserted mid-WDATA -> all outputs 0 immediately, FSM back to INIT.

Source files
------------

// File: rtl/ddr3_req_arbiter.sv
// Two-requester command scheduler for the DDR3 controller user interface.
// Runs controller init, round-robin arbitrates commands, steers write pulls and read returns.
module ddr3_req_arbiter #(
    parameter int unsigned BEATS_PER_BURST = 2,
    parameter int unsigned RD_TAG_DEPTH    = 4,
    parameter logic [3:0]  CMD_READ        = 4'b0001,
    parameter logic [3:0]  CMD_WRITE       = 4'b0010,
    parameter logic        OFLY_BL         = 1'b0
) (
    input  logic         sclk,
    input  logic         rst_n,

    input  logic         r0_req,
    input  logic         r0_rnw,
    input  logic [27:0]  r0_addr,
    input  logic [4:0]   r0_burst_cnt,
    output logic         r0_grant,
    input  logic [127:0] r0_wdata,
    input  logic [15:0]  r0_wmask,
    output logic         r0_wdata_rdy,
    output logic [127:0] r0_rdata,
    output logic         r0_rdata_valid,

    input  logic         r1_req,
    input  logic         r1_rnw,
    input  logic [27:0]  r1_addr,
    input  logic [4:0]   r1_burst_cnt,
    output logic         r1_grant,
    input  logic [127:0] r1_wdata,
    input  logic [15:0]  r1_wmask,
    output logic         r1_wdata_rdy,
    output logic [127:0] r1_rdata,
    output logic         r1_rdata_valid,

    output logic         init_start,
    input  logic         init_done,
    output logic [3:0]   cmd,
    output logic [27:0]  addr,
    output logic [4:0]   cmd_burst_cnt,
    output logic         cmd_valid,
    input  logic         cmd_rdy,
    input  logic         datain_rdy,
    output logic [127:0] write_data,
    output logic [15:0]  data_mask,
    input  logic [127:0] read_data,
    input  logic         read_data_valid,
    output logic         ofly_burst_len,
    output logic         busy,
    output logic         rd_err
);

    localparam int unsigned PtrW = (RD_TAG_DEPTH > 1) ? $clog2(RD_TAG_DEPTH) : 1;
    localparam int unsigned CntW = PtrW + 1;

    typedef enum logic [1:0] {StInit, StIdle, StCmd, StWdata} state_e;

    state_e       state_q, state_d;
    logic         rr_q, rr_d;
    logic         lat_id_q, lat_id_d;
    logic         lat_rnw_q, lat_rnw_d;
    logic [27:0]  lat_addr_q, lat_addr_d;
    logic [4:0]   lat_bc_q, lat_bc_d;
    logic [6:0]   wbeats_q, wbeats_d;
    logic [6:0]   lat_beats;
    logic         init_start_q, busy_q, rd_err_q;

    logic         tag_id_q [RD_TAG_DEPTH];
    logic [6:0]   tag_beats_q [RD_TAG_DEPTH];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0] count_q, count_d;
    logic [6:0]   head_done_q;

    logic         fifo_empty, fifo_full;
    logic         push, pop, beat_ok;
    logic         head_id;
    logic [6:0]   head_beats;
    logic         elig0, elig1, pick;

    // Burst count 0 encodes 32; the result always fits in 7 bits (max 64).
    assign lat_beats = 7'(((lat_bc_q == 5'd0) ? 32'd32 : {27'd0, lat_bc_q}) * BEATS_PER_BURST);

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CntW'(RD_TAG_DEPTH));
    assign elig0      = r0_req & (~r0_rnw | ~fifo_full);
    assign elig1      = r1_req & (~r1_rnw | ~fifo_full);

    always_comb begin
        state_d      = state_q;
        rr_d         = rr_q;
        lat_id_d     = lat_id_q;
        lat_rnw_d    = lat_rnw_q;
        lat_addr_d   = lat_addr_q;
        lat_bc_d     = lat_bc_q;
        wbeats_d     = wbeats_q;
        pick         = 1'b0;
        push         = 1'b0;
        cmd_valid    = 1'b0;
        cmd          = 4'b0000;
        r0_grant     = 1'b0;
        r1_grant     = 1'b0;
        r0_wdata_rdy = 1'b0;
        r1_wdata_rdy = 1'b0;
        unique case (state_q)
            StInit: begin
                if (init_done) state_d = StIdle;
            end
            StIdle: begin
                if (elig0 | elig1) begin
                    // rr_q names the requester favoured on a tie.
                    pick       = (elig0 & elig1) ? rr_q : elig1;
                    lat_id_d   = pick;
                    lat_rnw_d  = pick ? r1_rnw : r0_rnw;
                    lat_addr_d = pick ? r1_addr : r0_addr;
                    lat_bc_d   = pick ? r1_burst_cnt : r0_burst_cnt;
                    rr_d       = ~pick;
                    state_d    = StCmd;
                end
            end
            StCmd: begin
                cmd_valid = 1'b1;
                cmd       = lat_rnw_q ? CMD_READ : CMD_WRITE;
                if (cmd_rdy) begin
                    r0_grant = ~lat_id_q;
                    r1_grant = lat_id_q;
                    if (lat_rnw_q) begin
                        push    = 1'b1;
                        state_d = StIdle;
                    end else begin
                        wbeats_d = lat_beats;
                        state_d  = StWdata;
                    end
                end
            end
            StWdata: begin
                r0_wdata_rdy = datain_rdy & ~lat_id_q;
                r1_wdata_rdy = datain_rdy & lat_id_q;
                if (datain_rdy) begin
                    wbeats_d = wbeats_q - 7'd1;
                    if (wbeats_q == 7'd1) state_d = StIdle;
                end
            end
            default: state_d = StInit;
        endcase
    end

    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StInit;
            rr_q       <= 1'b0;
            lat_id_q   <= 1'b0;
            lat_rnw_q  <= 1'b0;
            lat_addr_q <= '0;
            lat_bc_q   <= '0;
            wbeats_q   <= '0;
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            lat_id_q   <= lat_id_d;
            lat_rnw_q  <= lat_rnw_d;
            lat_addr_q <= lat_addr_d;
            lat_bc_q   <= lat_bc_d;
            wbeats_q   <= wbeats_d;
        end
    end

    assign addr          = lat_addr_q;
    assign cmd_burst_cnt = lat_bc_q;
    assign write_data    = (state_q == StWdata && lat_id_q) ? r1_wdata : r0_wdata;
    assign data_mask     = (state_q == StWdata && lat_id_q) ? r1_wmask : r0_wmask;

    // Read tag FIFO: one entry per outstanding read, returned strictly in order.
    assign head_id        = tag_id_q[rd_ptr_q];
    assign head_beats     = tag_beats_q[rd_ptr_q];
    assign beat_ok        = read_data_valid & ~fifo_empty;
    assign pop            = beat_ok & ((head_done_q + 7'd1) == head_beats);
    assign r0_rdata_valid = beat_ok & ~head_id;
    assign r1_rdata_valid = beat_ok & head_id;
    assign r0_rdata       = read_data;
    assign r1_rdata       = read_data;

    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge sclk) begin
        if (push) begin
            tag_id_q[wr_ptr_q]    <= lat_id_q;
            tag_beats_q[wr_ptr_q] <= lat_beats;
        end
    end

    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            head_done_q <= '0;
        end else begin
            count_q <= count_d;
            if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (pop) rd_ptr_q <= rd_ptr_q + PtrW'(1);
            if (beat_ok) head_done_q <= pop ? 7'd0 : head_done_q + 7'd1;
        end
    end

    // Status outputs registered from next-state so they read 0 while in reset.
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            init_start_q <= 1'b0;
            busy_q       <= 1'b0;
            rd_err_q     <= 1'b0;
        end else begin
            init_start_q <= (state_d == StInit);
            busy_q       <= (state_d != StIdle) | (count_d != '0);
            rd_err_q     <= rd_err_q | (read_data_valid & fifo_empty);
        end
    end

    assign init_start     = init_start_q;
    assign busy           = busy_q;
    assign rd_err         = rd_err_q;
    assign ofly_burst_len = OFLY_BL;

endmodule

// File: tb/tb_ddr3_req_arbiter.sv
// Randomized and directed bench for ddr3_req_arbiter against a transaction-level model.
module tb_ddr3_req_arbiter;

    logic         sclk = 1'b0;
    logic         rst_n = 1'b0;
    logic         r0_req = 0, r0_rnw = 0, r1_req = 0, r1_rnw = 0;
    logic [27:0]  r0_addr = 0, r1_addr = 0;
    logic [4:0]   r0_burst_cnt = 0, r1_burst_cnt = 0;
    logic [127:0] r0_wdata = 0, r1_wdata = 0, read_data = 0;
    logic [15:0]  r0_wmask = 0, r1_wmask = 0;
    logic         init_done = 0, cmd_rdy = 0, datain_rdy = 0, read_data_valid = 0;
    logic         r0_grant, r1_grant, r0_wdata_rdy, r1_wdata_rdy, r0_rdata_valid, r1_rdata_valid;
    logic [127:0] r0_rdata, r1_rdata, write_data;
    logic [15:0]  data_mask;
    logic         init_start, cmd_valid, ofly_burst_len, busy, rd_err;
    logic [3:0]   cmd;
    logic [27:0]  addr;
    logic [4:0]   cmd_burst_cnt;

    ddr3_req_arbiter dut (
        .sclk(sclk), .rst_n(rst_n),
        .r0_req(r0_req), .r0_rnw(r0_rnw), .r0_addr(r0_addr), .r0_burst_cnt(r0_burst_cnt),
        .r0_grant(r0_grant), .r0_wdata(r0_wdata), .r0_wmask(r0_wmask),
        .r0_wdata_rdy(r0_wdata_rdy), .r0_rdata(r0_rdata), .r0_rdata_valid(r0_rdata_valid),
        .r1_req(r1_req), .r1_rnw(r1_rnw), .r1_addr(r1_addr), .r1_burst_cnt(r1_burst_cnt),
        .r1_grant(r1_grant), .r1_wdata(r1_wdata), .r1_wmask(r1_wmask),
        .r1_wdata_rdy(r1_wdata_rdy), .r1_rdata(r1_rdata), .r1_rdata_valid(r1_rdata_valid),
        .init_start(init_start), .init_done(init_done), .cmd(cmd), .addr(addr),
        .cmd_burst_cnt(cmd_burst_cnt), .cmd_valid(cmd_valid), .cmd_rdy(cmd_rdy),
        .datain_rdy(datain_rdy), .write_data(write_data), .data_mask(data_mask),
        .read_data(read_data), .read_data_valid(read_data_valid),
        .ofly_burst_len(ofly_burst_len), .busy(busy), .rd_err(rd_err)
    );

    always #5 sclk = ~sclk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Model: init phase, one pending command, write beats left, in-order read queue.
    bit         m_init, m_started, m_pend, m_rnw, m_err, m_fav, m_owner, m_g0, m_g1;
    int         m_id, m_wrem;
    logic [27:0] m_addr;
    logic [4:0] m_bc;
    int         q_id[$];
    int         q_beats[$];
    int         cnt_init, cnt_cv, cnt_g0, cnt_g1, cnt_wr0, cnt_rv0, cnt_rv1;
    int         gseq[$];
    bit         drv0, drv1;

    function automatic void model_reset();
        m_init = 1; m_started = 0; m_pend = 0; m_err = 0; m_fav = 0; m_owner = 0;
        m_wrem = 0; m_id = 0; m_rnw = 0; m_addr = 0; m_bc = 0;
        q_id.delete(); q_beats.delete();
    endfunction

    function automatic void clear_cnt();
        cnt_init = 0; cnt_cv = 0; cnt_g0 = 0; cnt_g1 = 0; cnt_wr0 = 0; cnt_rv0 = 0; cnt_rv1 = 0;
        gseq.delete();
    endfunction

    function automatic bit model_idle();
        return !m_pend && m_wrem == 0 && q_id.size() == 0;
    endfunction

    // One cycle: compare just before the rising edge, advance the model, return at negedge.
    task automatic step();
        int sz, hid, bc, e0, e1, win;
        logic [10:0] ectl;
        #1;
        sz  = q_id.size();
        hid = (sz > 0) ? q_id[0] : -1;
        m_g0 = m_pend && cmd_rdy && m_id == 0;
        m_g1 = m_pend && cmd_rdy && m_id == 1;
        ectl = {m_init && m_started, m_pend, m_g0, m_g1,
                m_wrem > 0 && datain_rdy && !m_owner, m_wrem > 0 && datain_rdy && m_owner,
                read_data_valid && hid == 0, read_data_valid && hid == 1,
                m_started && (m_init || m_pend || m_wrem > 0 || sz > 0), m_err, 1'b0};
        check("ctl", {init_start, cmd_valid, r0_grant, r1_grant, r0_wdata_rdy, r1_wdata_rdy,
                      r0_rdata_valid, r1_rdata_valid, busy, rd_err, ofly_burst_len}, ectl);
        if (m_pend)
            check("cmd", {cmd, addr, cmd_burst_cnt}, {(m_rnw ? 4'b0001 : 4'b0010), m_addr, m_bc});
        if (m_wrem > 0 && m_owner)
            check("wdata", {write_data, data_mask}, {r1_wdata, r1_wmask});
        else
            check("wdata", {write_data, data_mask}, {r0_wdata, r0_wmask});
        check("rdata", {r0_rdata, r1_rdata}, {read_data, read_data});
        cnt_init += int'(init_start); cnt_cv += int'(cmd_valid);
        cnt_g0 += int'(r0_grant); cnt_g1 += int'(r1_grant); cnt_wr0 += int'(r0_wdata_rdy);
        cnt_rv0 += int'(r0_rdata_valid); cnt_rv1 += int'(r1_rdata_valid);
        if (r0_grant) gseq.push_back(0);
        if (r1_grant) gseq.push_back(1);
        // model advance
        if (read_data_valid) begin
            if (sz == 0) m_err = 1;
            else begin
                q_beats[0] = q_beats[0] - 1;
                if (q_beats[0] == 0) begin
                    void'(q_id.pop_front());
                    void'(q_beats.pop_front());
                end
            end
        end
        if (m_init) begin
            if (init_done) m_init = 0;
        end else if (m_pend) begin
            if (cmd_rdy) begin
                m_pend = 0;
                bc = (m_bc == 0) ? 32 : int'(m_bc);
                if (m_rnw) begin
                    q_id.push_back(m_id);
                    q_beats.push_back(bc * 2);
                end else begin
                    m_wrem  = bc * 2;
                    m_owner = (m_id == 1);
                end
            end
        end else if (m_wrem > 0) begin
            if (datain_rdy) m_wrem--;
        end else begin
            e0 = int'(r0_req && (!r0_rnw || sz < 4));
            e1 = int'(r1_req && (!r1_rnw || sz < 4));
            if (e0 != 0 || e1 != 0) begin
                win    = (e0 != 0 && e1 != 0) ? int'(m_fav) : e1;
                m_fav  = (win == 0);
                m_pend = 1;
                m_id   = win;
                m_rnw  = (win == 1) ? r1_rnw : r0_rnw;
                m_addr = (win == 1) ? r1_addr : r0_addr;
                m_bc   = (win == 1) ? r1_burst_cnt : r0_burst_cnt;
            end
        end
        m_started = 1;
        @(negedge sclk);
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        #1;
        check("rst_ctl", {init_start, cmd_valid, r0_grant, r1_grant, r0_wdata_rdy, r1_wdata_rdy,
                          busy, rd_err, ofly_burst_len}, 9'd0);
        check("rst_cmd", {cmd, addr, cmd_burst_cnt}, 37'd0);
        model_reset();
        drv0 = 0; drv1 = 0;
        @(negedge sclk);
        @(negedge sclk);
        rst_n = 1'b1;
    endtask

    task automatic drain(input int bound);
        int n = 0;
        r0_req = 0; r1_req = 0; cmd_rdy = 1; datain_rdy = 1;
        while (!model_idle() && n < bound) begin
            read_data_valid = (q_id.size() > 0);
            read_data = {4{$urandom}};
            step();
            n++;
        end
        read_data_valid = 0; cmd_rdy = 0; datain_rdy = 0;
        check("drain_idle", 1'(model_idle()), 1'b1);
    endtask

    initial begin
        int n;
        @(negedge sclk);
        reset_dut();

        // Init handshake: init_done 20 cycles after release.
        clear_cnt();
        repeat (20) step();
        init_done = 1;
        step();
        step();
        check("init_cycles", 32'(cnt_init), 32'd20);
        check("no_cmd_in_init", 32'(cnt_cv), 32'd0);

        // Single write, cmd_rdy after three cycles of cmd_valid.
        clear_cnt();
        r0_req = 1; r0_rnw = 0; r0_addr = 28'h0000100; r0_burst_cnt = 5'd1;
        r0_wdata = {4{32'hA5A5_0001}}; r0_wmask = 16'h00FF;
        step();
        step();
        step();
        cmd_rdy = 1;
        step();
        r0_req = 0; cmd_rdy = 0; datain_rdy = 1;
        step();
        r0_wdata = {4{32'h5A5A_0002}};
        step();
        datain_rdy = 0;
        step();
        step();
        check("wr_cv_cycles", 32'(cnt_cv), 32'd3);
        check("wr_grants", 32'(cnt_g0), 32'd1);
        check("wr_beats", 32'(cnt_wr0), 32'd2);

        // Both requesters continuously: grants alternate.
        clear_cnt();
        r0_req = 1; r0_rnw = 0; r0_burst_cnt = 1; r1_req = 1; r1_rnw = 0; r1_burst_cnt = 1;
        r1_addr = 28'h0ABCDEF; r1_wdata = {4{32'hCAFE_F00D}}; r1_wmask = 16'hF0F0;
        cmd_rdy = 1; datain_rdy = 1;
        n = int'(m_fav);
        repeat (40) step();
        check("alt_count", 1'(gseq.size() >= 6), 1'b1);
        foreach (gseq[i]) check("alt_order", 32'(gseq[i]), 32'((n + i) % 2));
        drain(50);

        // r1 read of burst_cnt 0 returns 64 beats to r1 only.
        clear_cnt();
        r1_req = 1; r1_rnw = 1; r1_burst_cnt = 0; cmd_rdy = 1;
        n = 0;
        while (cnt_g1 == 0 && n < 10) begin step(); n++; end
        r1_req = 0; cmd_rdy = 0;
        check("rd64_grant", 32'(cnt_g1), 32'd1);
        read_data_valid = 1;
        for (int i = 0; i < 64; i++) begin
            read_data = {4{$urandom}};
            step();
        end
        read_data_valid = 0;
        step();
        check("rd64_r1", 32'(cnt_rv1), 32'd64);
        check("rd64_r0", 32'(cnt_rv0), 32'd0);

        // Tag FIFO full: fifth read blocked, write still granted.
        clear_cnt();
        r0_req = 1; r0_rnw = 1; r0_burst_cnt = 1; cmd_rdy = 1;
        repeat (20) step();
        check("full_reads", 32'(cnt_g0), 32'd4);
        r1_req = 1; r1_rnw = 0; r1_burst_cnt = 1; datain_rdy = 1;
        n = 0;
        while ((cnt_g1 == 0 || m_wrem > 0) && n < 20) begin
            step();
            if (m_g1) r1_req = 0;
            n++;
        end
        r1_req = 0;
        check("full_wr_grant", 32'(cnt_g1), 32'd1);
        check("full_still_4", 32'(cnt_g0), 32'd4);
        read_data_valid = 1;
        step();
        step();
        read_data_valid = 0;
        n = 0;
        while (cnt_g0 < 5 && n < 10) begin
            step();
            if (m_g0) r0_req = 0;
            n++;
        end
        r0_req = 0;
        check("full_fifth", 32'(cnt_g0), 32'd5);
        drain(60);

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            if (!drv0) begin
                r0_req = ($urandom % 3 == 0);
                r0_rnw = 1'($urandom); r0_addr = 28'($urandom);
                r0_burst_cnt = ($urandom % 8 == 0) ? 5'd0 : 5'(1 + $urandom % 3);
                drv0 = r0_req;
            end
            if (!drv1) begin
                r1_req = ($urandom % 3 == 0);
                r1_rnw = 1'($urandom); r1_addr = 28'($urandom);
                r1_burst_cnt = ($urandom % 8 == 0) ? 5'd0 : 5'(1 + $urandom % 3);
                drv1 = r1_req;
            end
            r0_wdata = {4{$urandom}}; r1_wdata = {4{$urandom}};
            r0_wmask = 16'($urandom); r1_wmask = 16'($urandom);
            cmd_rdy = 1'($urandom); datain_rdy = ($urandom % 4 != 0);
            read_data_valid = (q_id.size() > 0) && ($urandom % 2 == 0);
            read_data = {4{$urandom}};
            step();
            if (m_g0) begin drv0 = 0; r0_req = 0; end
            if (m_g1) begin drv1 = 0; r1_req = 0; end
        end
        drain(400);

        // Stray read beat sets sticky rd_err.
        read_data_valid = 1;
        step();
        read_data_valid = 0;
        repeat (3) step();
        check("rd_err_sticky", 1'(rd_err), 1'b1);

        // Async reset in the middle of a write burst.
        r0_req = 1; r0_rnw = 0; r0_burst_cnt = 5'd3; cmd_rdy = 1; datain_rdy = 1;
        n = 0;
        while (m_wrem == 0 && n < 10) begin step(); n++; end
        r0_req = 0;
        step();
        check("mid_wdata", 1'(m_wrem > 0), 1'b1);
        #2;
        reset_dut();
        cmd_rdy = 0; datain_rdy = 0;
        repeat (3) step();
        check("post_rst_err", 1'(rd_err), 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
